// File: rtl/axi_buffer_slice.sv
// AXI4 buffer slice: one FIFO per channel (AW, W, B, AR, R) between an
// upstream (slv_*) and a downstream (mst_*) port, plus outstanding-transaction
// limiters that hold off new AW/AR requests once a direction is saturated.
// A channel depth of 0 turns that channel into a combinational passthrough.

// Per-channel FIFO; DEPTH 0 is a wire-through with reset gating only.
module axi_buffer_slice_fifo #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   if (DEPTH == 0) begin : g_pass
      assign out_valid = in_valid & ~rst;
      assign in_ready  = out_ready & ~rst;
      assign out_data  = in_data;
   end else begin : g_fifo
      localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
      localparam int CNT_W = $clog2(DEPTH) + 1;

      logic [WIDTH-1:0] mem [DEPTH];
      logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
      logic [CNT_W-1:0] count;
      logic             full, empty, push, pop;

      assign full  = (count == CNT_W'(DEPTH));
      assign empty = (count == '0);
      // Ready depends only on fullness, so a full FIFO refuses a push even
      // when a pop happens in the same cycle.
      assign push  = in_valid & ~full & ~rst;
      assign pop   = out_ready & ~empty & ~rst;

      assign in_ready  = ~full & ~rst;
      assign out_valid = ~empty & ~rst;
      assign out_data  = mem[rd_ptr];

      assign wr_ptr_nxt = (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      assign rd_ptr_nxt = (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);

      // Pointer and occupancy bookkeeping.
      always_ff @(posedge clk) begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register sees the pre-edge values of the others.
         if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr_nxt;
            if (pop)  rd_ptr <= rd_ptr_nxt;
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
         end
      end

      // Entry storage.
      always_ff @(posedge clk) begin
         // NOTE: storage is not reset; the cleared occupancy count already
         // makes stale entries invisible, and leaving it unreset keeps it a
         // plain register file.
         if (push) mem[wr_ptr] <= in_data;
      end
   end

endmodule

module axi_buffer_slice #(
   parameter int ADDR_WIDTH         = 32,
   parameter int DATA_WIDTH         = 32,
   parameter int ID_WIDTH           = 4,
   parameter int AW_DEPTH           = 2,
   parameter int W_DEPTH            = 2,
   parameter int B_DEPTH            = 2,
   parameter int AR_DEPTH           = 2,
   parameter int R_DEPTH            = 2,
   parameter int MAX_WR_OUTSTANDING = 8,
   parameter int MAX_RD_OUTSTANDING = 8
) (
   input  logic                    aclk,
   input  logic                    areset,
   // upstream AW
   input  logic [ID_WIDTH-1:0]     slv_aw_id,
   input  logic [ADDR_WIDTH-1:0]   slv_aw_addr,
   input  logic [7:0]              slv_aw_len,
   input  logic [2:0]              slv_aw_size,
   input  logic [1:0]              slv_aw_burst,
   input  logic                    slv_aw_lock,
   input  logic [3:0]              slv_aw_cache,
   input  logic [2:0]              slv_aw_prot,
   input  logic [3:0]              slv_aw_qos,
   input  logic [3:0]              slv_aw_region,
   input  logic                    slv_aw_valid,
   output logic                    slv_aw_ready,
   // upstream W
   input  logic [DATA_WIDTH-1:0]   slv_w_data,
   input  logic [DATA_WIDTH/8-1:0] slv_w_strb,
   input  logic                    slv_w_last,
   input  logic                    slv_w_valid,
   output logic                    slv_w_ready,
   // upstream B
   output logic [ID_WIDTH-1:0]     slv_b_id,
   output logic [1:0]              slv_b_resp,
   output logic                    slv_b_valid,
   input  logic                    slv_b_ready,
   // upstream AR
   input  logic [ID_WIDTH-1:0]     slv_ar_id,
   input  logic [ADDR_WIDTH-1:0]   slv_ar_addr,
   input  logic [7:0]              slv_ar_len,
   input  logic [2:0]              slv_ar_size,
   input  logic [1:0]              slv_ar_burst,
   input  logic                    slv_ar_lock,
   input  logic [3:0]              slv_ar_cache,
   input  logic [2:0]              slv_ar_prot,
   input  logic [3:0]              slv_ar_qos,
   input  logic [3:0]              slv_ar_region,
   input  logic                    slv_ar_valid,
   output logic                    slv_ar_ready,
   // upstream R
   output logic [ID_WIDTH-1:0]     slv_r_id,
   output logic [DATA_WIDTH-1:0]   slv_r_data,
   output logic [1:0]              slv_r_resp,
   output logic                    slv_r_last,
   output logic                    slv_r_valid,
   input  logic                    slv_r_ready,
   // downstream AW
   output logic [ID_WIDTH-1:0]     mst_aw_id,
   output logic [ADDR_WIDTH-1:0]   mst_aw_addr,
   output logic [7:0]              mst_aw_len,
   output logic [2:0]              mst_aw_size,
   output logic [1:0]              mst_aw_burst,
   output logic                    mst_aw_lock,
   output logic [3:0]              mst_aw_cache,
   output logic [2:0]              mst_aw_prot,
   output logic [3:0]              mst_aw_qos,
   output logic [3:0]              mst_aw_region,
   output logic                    mst_aw_valid,
   input  logic                    mst_aw_ready,
   // downstream W
   output logic [DATA_WIDTH-1:0]   mst_w_data,
   output logic [DATA_WIDTH/8-1:0] mst_w_strb,
   output logic                    mst_w_last,
   output logic                    mst_w_valid,
   input  logic                    mst_w_ready,
   // downstream B
   input  logic [ID_WIDTH-1:0]     mst_b_id,
   input  logic [1:0]              mst_b_resp,
   input  logic                    mst_b_valid,
   output logic                    mst_b_ready,
   // downstream AR
   output logic [ID_WIDTH-1:0]     mst_ar_id,
   output logic [ADDR_WIDTH-1:0]   mst_ar_addr,
   output logic [7:0]              mst_ar_len,
   output logic [2:0]              mst_ar_size,
   output logic [1:0]              mst_ar_burst,
   output logic                    mst_ar_lock,
   output logic [3:0]              mst_ar_cache,
   output logic [2:0]              mst_ar_prot,
   output logic [3:0]              mst_ar_qos,
   output logic [3:0]              mst_ar_region,
   output logic                    mst_ar_valid,
   input  logic                    mst_ar_ready,
   // downstream R
   input  logic [ID_WIDTH-1:0]     mst_r_id,
   input  logic [DATA_WIDTH-1:0]   mst_r_data,
   input  logic [1:0]              mst_r_resp,
   input  logic                    mst_r_last,
   input  logic                    mst_r_valid,
   output logic                    mst_r_ready
);

   localparam int AX_W = ID_WIDTH + ADDR_WIDTH + 29;
   localparam int W_W  = DATA_WIDTH + DATA_WIDTH / 8 + 1;
   localparam int B_W  = ID_WIDTH + 2;
   localparam int R_W  = ID_WIDTH + DATA_WIDTH + 3;

   localparam logic [7:0] WR_LIMIT = 8'(MAX_WR_OUTSTANDING);
   localparam logic [7:0] RD_LIMIT = 8'(MAX_RD_OUTSTANDING);

   logic [7:0]      wr_cnt, rd_cnt;
   logic            wr_block, rd_block;
   logic            aw_in_ready, ar_in_ready;
   logic            aw_hs, b_hs, ar_hs, r_last_hs;
   logic [AX_W-1:0] aw_in, aw_out, ar_in, ar_out;
   logic [W_W-1:0]  w_in, w_out;
   logic [B_W-1:0]  b_in, b_out;
   logic [R_W-1:0]  r_in, r_out;

   // A saturated direction refuses new requests; entries already buffered
   // still drain because only the input side is gated.
   assign wr_block = (MAX_WR_OUTSTANDING != 0) && (wr_cnt == WR_LIMIT);
   assign rd_block = (MAX_RD_OUTSTANDING != 0) && (rd_cnt == RD_LIMIT);

   assign slv_aw_ready = aw_in_ready & ~wr_block;
   assign slv_ar_ready = ar_in_ready & ~rd_block;

   assign aw_hs     = slv_aw_valid & slv_aw_ready;
   assign b_hs      = slv_b_valid & slv_b_ready;
   assign ar_hs     = slv_ar_valid & slv_ar_ready;
   assign r_last_hs = slv_r_valid & slv_r_ready & slv_r_last;

   assign aw_in = {slv_aw_id, slv_aw_addr, slv_aw_len, slv_aw_size, slv_aw_burst,
                   slv_aw_lock, slv_aw_cache, slv_aw_prot, slv_aw_qos, slv_aw_region};
   assign {mst_aw_id, mst_aw_addr, mst_aw_len, mst_aw_size, mst_aw_burst,
           mst_aw_lock, mst_aw_cache, mst_aw_prot, mst_aw_qos, mst_aw_region} = aw_out;

   assign w_in = {slv_w_data, slv_w_strb, slv_w_last};
   assign {mst_w_data, mst_w_strb, mst_w_last} = w_out;

   assign b_in = {mst_b_id, mst_b_resp};
   assign {slv_b_id, slv_b_resp} = b_out;

   assign ar_in = {slv_ar_id, slv_ar_addr, slv_ar_len, slv_ar_size, slv_ar_burst,
                   slv_ar_lock, slv_ar_cache, slv_ar_prot, slv_ar_qos, slv_ar_region};
   assign {mst_ar_id, mst_ar_addr, mst_ar_len, mst_ar_size, mst_ar_burst,
           mst_ar_lock, mst_ar_cache, mst_ar_prot, mst_ar_qos, mst_ar_region} = ar_out;

   assign r_in = {mst_r_id, mst_r_data, mst_r_resp, mst_r_last};
   assign {slv_r_id, slv_r_data, slv_r_resp, slv_r_last} = r_out;

   axi_buffer_slice_fifo #(.WIDTH(AX_W), .DEPTH(AW_DEPTH)) u_aw_fifo (
      .clk(aclk), .rst(areset),
      .in_valid(slv_aw_valid & ~wr_block), .in_ready(aw_in_ready), .in_data(aw_in),
      .out_valid(mst_aw_valid), .out_ready(mst_aw_ready), .out_data(aw_out));

   axi_buffer_slice_fifo #(.WIDTH(W_W), .DEPTH(W_DEPTH)) u_w_fifo (
      .clk(aclk), .rst(areset),
      .in_valid(slv_w_valid), .in_ready(slv_w_ready), .in_data(w_in),
      .out_valid(mst_w_valid), .out_ready(mst_w_ready), .out_data(w_out));

   axi_buffer_slice_fifo #(.WIDTH(B_W), .DEPTH(B_DEPTH)) u_b_fifo (
      .clk(aclk), .rst(areset),
      .in_valid(mst_b_valid), .in_ready(mst_b_ready), .in_data(b_in),
      .out_valid(slv_b_valid), .out_ready(slv_b_ready), .out_data(b_out));

   axi_buffer_slice_fifo #(.WIDTH(AX_W), .DEPTH(AR_DEPTH)) u_ar_fifo (
      .clk(aclk), .rst(areset),
      .in_valid(slv_ar_valid & ~rd_block), .in_ready(ar_in_ready), .in_data(ar_in),
      .out_valid(mst_ar_valid), .out_ready(mst_ar_ready), .out_data(ar_out));

   axi_buffer_slice_fifo #(.WIDTH(R_W), .DEPTH(R_DEPTH)) u_r_fifo (
      .clk(aclk), .rst(areset),
      .in_valid(mst_r_valid), .in_ready(mst_r_ready), .in_data(r_in),
      .out_valid(slv_r_valid), .out_ready(slv_r_ready), .out_data(r_out));

   // Outstanding writes: +1 per accepted AW, -1 per delivered B.
   always_ff @(posedge aclk) begin
      if (areset) begin
         wr_cnt <= '0;
      end else if (MAX_WR_OUTSTANDING != 0) begin
         if (aw_hs && !b_hs) begin
            wr_cnt <= wr_cnt + 8'd1;
         end else if (b_hs && !aw_hs) begin
            assert (wr_cnt != '0);
            if (wr_cnt != '0) wr_cnt <= wr_cnt - 8'd1;
         end
      end
   end

   // Outstanding reads: +1 per accepted AR, -1 per delivered last R beat.
   always_ff @(posedge aclk) begin
      if (areset) begin
         rd_cnt <= '0;
      end else if (MAX_RD_OUTSTANDING != 0) begin
         if (ar_hs && !r_last_hs) begin
            rd_cnt <= rd_cnt + 8'd1;
         end else if (r_last_hs && !ar_hs) begin
            assert (rd_cnt != '0);
            if (rd_cnt != '0) rd_cnt <= rd_cnt - 8'd1;
         end
      end
   end

endmodule
